// File: rtl/dmem_axi_bridge.sv
// dmem_axi_bridge: responder for the data-side req/addr_ok/data_ok port, one single-beat AXI4 transaction at a time.
// Optional build macro DMEM_BRIDGE_EARLY_WRITE_ACK_EN: stores complete once AW and W are done, B is collected afterwards.
module dmem_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata_axi,
  input  logic        rlast,
  input  logic [1:0]  rresp,
  input  logic [3:0]  rid,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata_axi,
  output logic [3:0]  wstrb_axi,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  output logic [2:0]  dbg_state
);

  // Handshake rule on every AXI channel: a beat transfers at the rising edge where valid && ready are
  // both high; a raised valid stays high with its payload stable until that edge. On the SRAM side the
  // request transfers on a cycle with req && addr_ok, and data_ok is a one-cycle completion pulse.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_AR  = 3'd1,
    S_RD_R   = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_ACK = 3'd4,
    S_WR_B   = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done_q, w_done_q, data_ok_q;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q    <= addr;
            size_q    <= size;
            wstrb_q   <= wstrb;
            wdata_q   <= wdata;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (we) begin
              state_q   <= S_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_RD_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_R;
          end
        end
        S_RD_R: begin
          // Error responses complete like any other; rresp is not inspected.
          if (rvalid) begin
            rready_q  <= 1'b0;
            rdata_q   <= rdata_axi;
            data_ok_q <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
`ifdef DMEM_BRIDGE_EARLY_WRITE_ACK_EN
            state_q   <= S_WR_ACK;
            data_ok_q <= 1'b1;
`else
            state_q  <= S_WR_B;
            bready_q <= 1'b1;
`endif
          end
        end
        S_WR_ACK: begin
          state_q  <= S_WR_B;
          bready_q <= 1'b1;
        end
        S_WR_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
`ifdef DMEM_BRIDGE_EARLY_WRITE_ACK_EN
            state_q <= S_IDLE;
`else
            state_q   <= S_RESP;
            data_ok_q <= 1'b1;
`endif
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_ok   = req && (state_q == S_IDLE);
  assign data_ok   = data_ok_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign rready  = rready_q;

  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awsize    = {1'b0, size_q};
  assign awid      = AXI_ID;
  assign awlen     = 8'd0;
  assign awburst   = 2'b01;
  assign wvalid    = wvalid_q;
  assign wdata_axi = wdata_q;
  assign wstrb_axi = wstrb_q;
  assign wlast     = 1'b1;
  assign bready    = bready_q;

  // Single-beat responses with a fixed ID carry nothing this bridge acts on.
  logic unused_resp;
  assign unused_resp = ^{rlast, rresp, rid, bresp, bid};

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Bench for dmem_axi_bridge: directed and random loads/stores against a delay-programmable AXI slave.
// Expected completion timing is derived from handshake delays; load data goes through an expected queue.
module tb_dmem_axi_bridge;

`ifdef DMEM_BRIDGE_EARLY_WRITE_ACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata_axi;
  logic [3:0]  wstrb_axi;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic [2:0]  dbg_state;

  dmem_axi_bridge dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize), .arid(arid),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata_axi(rdata_axi), .rlast(rlast), .rresp(rresp), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize), .awid(awid),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .dbg_state(dbg_state)
  );

  int n_checks, n_errors, cyc;
  int ar_d, r_d, aw_d, w_d, b_d;
  int ar_cnt, aw_cnt, w_cnt, r_wait, b_wait;
  bit r_pend, b_pend, aw_seen, w_seen;
  logic [31:0] r_dat, x_addr, x_wdata;
  logic [1:0]  x_size, x_resp;
  logic [3:0]  x_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  int s_cyc, n_ar, n_r, n_aw, n_w, n_b, ar_cyc, aw_cyc, w_cyc;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_clear();
    r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_wait = 0; b_wait = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
  endtask

  // One clock: sample mid-cycle, then update the slave just after the edge.
  task automatic cycle();
    logic hs_ar, hs_r, hs_aw, hs_w, hs_b;
    @(negedge clk);
    s_cyc = cyc; s_addr_ok = addr_ok; s_data_ok = data_ok; s_rdata = rdata;
    hs_ar = arvalid && arready; hs_r = rvalid && rready;
    hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
    if (hs_ar) begin
      n_ar++; ar_cyc = cyc;
      chk("araddr", araddr, x_addr);
      chk("arsize", arsize, {1'b0, x_size});
      chk("ar_id_len_burst", {arid, arlen, arburst}, {4'd1, 8'd0, 2'b01});
    end
    if (hs_aw) begin
      n_aw++; aw_cyc = cyc;
      chk("awaddr", awaddr, x_addr);
      chk("awsize", awsize, {1'b0, x_size});
      chk("aw_id_len_burst", {awid, awlen, awburst}, {4'd1, 8'd0, 2'b01});
    end
    if (hs_w) begin
      n_w++; w_cyc = cyc;
      chk("wdata_axi", wdata_axi, x_wdata);
      chk("wstrb_axi", wstrb_axi, x_wstrb);
      chk("wlast", wlast, 1);
    end
    if (hs_r) n_r++;
    if (hs_b) n_b++;
    @(posedge clk); #1;
    cyc++;
    if (hs_r) r_pend = 0;
    if (hs_ar) begin r_pend = 1; r_wait = r_d; end
    if (hs_b) b_pend = 0;
    if (hs_aw) aw_seen = 1;
    if (hs_w) w_seen = 1;
    if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_wait = b_d; end
    if (r_pend && r_wait == 0) rvalid = 1;
    else begin rvalid = 0; if (r_pend) r_wait--; end
    if (b_pend && b_wait == 0) bvalid = 1;
    else begin bvalid = 0; if (b_pend) b_wait--; end
    rdata_axi = rvalid ? r_dat : $urandom;
    rresp = x_resp; rid = 4'($urandom_range(0, 15)); rlast = 1;
    bresp = 2'($urandom_range(0, 3)); bid = 4'($urandom_range(0, 15));
    arready = arvalid && (ar_cnt >= ar_d);
    ar_cnt = (arvalid && !arready) ? ar_cnt + 1 : 0;
    awready = awvalid && (aw_cnt >= aw_d);
    aw_cnt = (awvalid && !awready) ? aw_cnt + 1 : 0;
    wready = wvalid && (w_cnt >= w_d);
    w_cnt = (wvalid && !wready) ? w_cnt + 1 : 0;
  endtask

  // Issue one request (req kept high afterwards) and follow it to the cycle the next one may be accepted.
  task automatic do_txn(input logic t_we, input logic [1:0] t_size, input logic [31:0] t_addr,
                        input logic [3:0] t_wstrb, input logic [31:0] t_wdata,
                        input int d_ar, input int d_r, input int d_aw, input int d_w, input int d_b,
                        input logic [1:0] t_resp, input logic [31:0] t_rdat);
    int t_acc, t_done, t_next, lw, n_dok, dok_cyc;
    ar_d = d_ar; r_d = d_r; aw_d = d_aw; w_d = d_w; b_d = d_b;
    x_addr = t_addr; x_size = t_size; x_wstrb = t_wstrb; x_wdata = t_wdata; x_resp = t_resp;
    r_dat = t_rdat;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0; ar_cyc = -1; aw_cyc = -1; w_cyc = -1;
    if (!t_we) exp_q.push_back(t_rdat);
    req = 1; we = t_we; size = t_size; addr = t_addr; wstrb = t_wstrb; wdata = t_wdata;
    t_acc = cyc;
    cycle();
    chk("accept_now", s_addr_ok, 1);
    if (!t_we) begin
      t_done = t_acc + 3 + d_ar + d_r;
      t_next = t_done + 1;
    end else begin
      lw = t_acc + 1 + ((d_aw > d_w) ? d_aw : d_w);
      if (EARLY) begin
        t_done = lw + 1;
        t_next = (3 > 2 + d_b) ? lw + 3 : lw + 2 + d_b;
      end else begin
        t_done = lw + 2 + d_b;
        t_next = t_done + 1;
      end
    end
    n_dok = 0; dok_cyc = -1;
    while (cyc < t_next) begin
      cycle();
      chk("busy_addr_ok", s_addr_ok, 0);
      if (s_data_ok) begin
        n_dok++; dok_cyc = s_cyc;
        if (!t_we && exp_q.size() > 0) chk("load_rdata", s_rdata, exp_q.pop_front());
      end
    end
    chk("data_ok_count", n_dok, 1);
    chk("data_ok_cycle", dok_cyc, t_done);
    chk("ar_count", n_ar, t_we ? 0 : 1);
    chk("r_count", n_r, t_we ? 0 : 1);
    chk("aw_count", n_aw, t_we ? 1 : 0);
    chk("w_count", n_w, t_we ? 1 : 0);
    chk("b_count", n_b, t_we ? 1 : 0);
    if (t_we) begin
      chk("aw_cycle", aw_cyc, t_acc + 1 + d_aw);
      chk("w_cycle", w_cyc, t_acc + 1 + d_w);
    end else begin
      chk("ar_cycle", ar_cyc, t_acc + 1 + d_ar);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    req = 0; we = 0; size = 0; addr = 0; wstrb = 0; wdata = 0; reset = 1;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
    x_addr = 0; x_size = 0; x_wstrb = 0; x_wdata = 0; x_resp = 0; r_dat = 0;
    slave_clear();
    rdata_axi = 0; rresp = 0; rid = 0; rlast = 1; bresp = 0; bid = 0;
    repeat (3) cycle();
    chk("rst_data_ok", data_ok, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_readies", {rready, bready}, 2'b00);
    chk("rst_rdata", rdata, 0);
    chk("rst_state", dbg_state, 0);
    reset = 0;

    // Directed: zero-wait load, late-W byte store, delayed B, error response on a load.
    do_txn(0, 2'd2, 32'h1C000010, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF);
    do_txn(1, 2'd0, 32'h00000003, 4'b1000, 32'h55555555, 0, 0, 0, 2, 0, 2'b00, 32'h0);
    do_txn(1, 2'd2, 32'h80001000, 4'hF, 32'h12345678, 0, 0, 0, 0, 5, 2'b00, 32'h0);
    do_txn(0, 2'd1, 32'h1C000022, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b10, 32'hCAFEF00D);
    // W ahead of AW, zero strobe store.
    do_txn(1, 2'd1, 32'h00000102, 4'h0, 32'hA5A5A5A5, 3, 0, 3, 0, 1, 2'b00, 32'h0);
    // Back-to-back load-store-load with req never dropped.
    do_txn(0, 2'd2, 32'h00002000, 4'h0, 32'h0, 1, 2, 0, 0, 0, 2'b00, 32'h11112222);
    do_txn(1, 2'd2, 32'h00002004, 4'hF, 32'h33334444, 0, 0, 1, 1, 2, 2'b00, 32'h0);
    do_txn(0, 2'd0, 32'h00002007, 4'h0, 32'h0, 0, 3, 0, 0, 0, 2'b01, 32'h55556666);

    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, 4'($urandom_range(0, 15)),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 4), 2'($urandom_range(0, 3)), $urandom);
    end

    // Reset while in the R phase with rvalid up.
    ar_d = 0; r_d = 1; x_addr = 32'h1C0000F0; x_size = 2'd2; x_resp = 2'b00; r_dat = 32'h0BADF00D;
    req = 1; we = 0; size = 2'd2; addr = 32'h1C0000F0;
    cycle();
    chk("rst_mid_accept", s_addr_ok, 1);
    req = 0;
    cycle();
    cycle();
    chk("rst_mid_in_r", rready, 1);
    reset = 1;
    cycle();
    chk("rst_mid_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_mid_readies", {rready, bready}, 2'b00);
    chk("rst_mid_state", dbg_state, 0);
    chk("rst_mid_rdata", rdata, 0);
    reset = 0;
    slave_clear();
    cycle();
    chk("rst_mid_no_data_ok", s_data_ok, 0);
    do_txn(0, 2'd2, 32'h1C000100, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h76543210);
    do_txn(1, 2'd2, 32'h1C000104, 4'h3, 32'h89ABCDEF, 1, 0, 0, 1, 0, 2'b00, 32'h0);
    req = 0;
    cycle();
    chk("idle_no_data_ok", s_data_ok, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
